// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, funcs, ALU ops,
// FSM states, datapath mux selects and the decoded-instruction record.
package mcu_pkg;

    localparam logic [5:0] OpRtype  = 6'b000000;
    localparam logic [5:0] OpRegimm = 6'b000001;
    localparam logic [5:0] OpJ      = 6'b000010;
    localparam logic [5:0] OpJal    = 6'b000011;
    localparam logic [5:0] OpBeq    = 6'b000100;
    localparam logic [5:0] OpBne    = 6'b000101;
    localparam logic [5:0] OpBlez   = 6'b000110;
    localparam logic [5:0] OpBgtz   = 6'b000111;
    localparam logic [5:0] OpAddi   = 6'b001000;
    localparam logic [5:0] OpAddiu  = 6'b001001;
    localparam logic [5:0] OpSlti   = 6'b001010;
    localparam logic [5:0] OpSltiu  = 6'b001011;
    localparam logic [5:0] OpAndi   = 6'b001100;
    localparam logic [5:0] OpOri    = 6'b001101;
    localparam logic [5:0] OpXori   = 6'b001110;
    localparam logic [5:0] OpLui    = 6'b001111;
    localparam logic [5:0] OpLw     = 6'b100011;
    localparam logic [5:0] OpSw     = 6'b101011;

    localparam logic [5:0] FnSll     = 6'b000000;
    localparam logic [5:0] FnSrl     = 6'b000010;
    localparam logic [5:0] FnSra     = 6'b000011;
    localparam logic [5:0] FnJr      = 6'b001000;
    localparam logic [5:0] FnSyscall = 6'b001100;
    localparam logic [5:0] FnMult    = 6'b011000;
    localparam logic [5:0] FnMultu   = 6'b011001;
    localparam logic [5:0] FnDiv     = 6'b011010;
    localparam logic [5:0] FnDivu    = 6'b011011;
    localparam logic [5:0] FnAdd     = 6'b100000;
    localparam logic [5:0] FnAddu    = 6'b100001;
    localparam logic [5:0] FnSub     = 6'b100010;
    localparam logic [5:0] FnSubu    = 6'b100011;
    localparam logic [5:0] FnAnd     = 6'b100100;
    localparam logic [5:0] FnOr      = 6'b100101;
    localparam logic [5:0] FnXor     = 6'b100110;
    localparam logic [5:0] FnNor     = 6'b100111;
    localparam logic [5:0] FnSlt     = 6'b101010;
    localparam logic [5:0] FnSltu    = 6'b101011;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluNor  = 4'd5;
    localparam logic [3:0] AluSlt  = 4'd6;
    localparam logic [3:0] AluSltu = 4'd7;
    localparam logic [3:0] AluSll  = 4'd8;
    localparam logic [3:0] AluSrl  = 4'd9;
    localparam logic [3:0] AluSra  = 4'd10;
    localparam logic [3:0] AluLui  = 4'd11;

    typedef enum logic [2:0] {
        StFetch      = 3'd0,
        StDecode     = 3'd1,
        StExec       = 3'd2,
        StMuldivWait = 3'd3,
        StMem        = 3'd4,
        StWb         = 3'd5,
        StHalt       = 3'd6
    } state_e;

    typedef enum logic [1:0] {PcSrcPlus4, PcSrcBranch, PcSrcJump, PcSrcReg} pc_src_e;
    typedef enum logic [1:0] {WbAlu, WbMem, WbLink, WbMulDiv} wb_src_e;
    typedef enum logic [1:0] {DestRt, DestRd, DestR31} reg_dest_e;

    typedef enum logic [3:0] {
        ClsIllegal, ClsAluR, ClsAluImm, ClsLoad, ClsStore, ClsMulDiv,
        ClsBranch, ClsJump, ClsJr, ClsJal, ClsSyscall
    } instr_class_e;

    typedef enum logic [2:0] {BrEq, BrNe, BrLez, BrGtz, BrGez} branch_e;

    typedef struct packed {
        instr_class_e cls;
        branch_e      br;
        logic [3:0]   alu_op;
        logic         alu_src;
        logic         shamt;
        logic         is_unsigned;
        logic         illegal;
    } dec_t;

endpackage

// File: rtl/mcu_decode.sv
// Combinational instruction decoder: opcode/func to instruction class, branch kind,
// ALU controls, immediate extension and illegal flag.
module mcu_decode
    import mcu_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] func_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o     = '0;
        dec_o.cls = ClsIllegal;
        dec_o.br  = BrEq;
        unique case (opcode_i)
            OpRtype: begin
                dec_o.cls = ClsAluR;
                unique case (func_i)
                    FnSll:          begin dec_o.alu_op = AluSll; dec_o.shamt = 1'b1; end
                    FnSrl:          begin dec_o.alu_op = AluSrl; dec_o.shamt = 1'b1; end
                    FnSra:          begin dec_o.alu_op = AluSra; dec_o.shamt = 1'b1; end
                    FnAdd, FnAddu:  dec_o.alu_op = AluAdd;
                    FnSub, FnSubu:  dec_o.alu_op = AluSub;
                    FnAnd:          dec_o.alu_op = AluAnd;
                    FnOr:           dec_o.alu_op = AluOr;
                    FnXor:          dec_o.alu_op = AluXor;
                    FnNor:          dec_o.alu_op = AluNor;
                    FnSlt:          dec_o.alu_op = AluSlt;
                    FnSltu:         dec_o.alu_op = AluSltu;
                    FnJr:           dec_o.cls = ClsJr;
                    FnSyscall:      dec_o.cls = ClsSyscall;
                    FnMult, FnMultu, FnDiv, FnDivu: dec_o.cls = ClsMulDiv;
                    default:        dec_o.cls = ClsIllegal;
                endcase
            end
            OpAddi, OpAddiu: begin
                dec_o.cls = ClsAluImm; dec_o.alu_src = 1'b1; dec_o.alu_op = AluAdd;
            end
            OpSlti: begin
                dec_o.cls = ClsAluImm; dec_o.alu_src = 1'b1; dec_o.alu_op = AluSlt;
            end
            OpSltiu: begin
                dec_o.cls = ClsAluImm; dec_o.alu_src = 1'b1; dec_o.alu_op = AluSltu;
            end
            // Logical immediates zero-extend; arithmetic ones sign-extend.
            OpAndi: begin
                dec_o.cls = ClsAluImm; dec_o.alu_src = 1'b1; dec_o.alu_op = AluAnd;
                dec_o.is_unsigned = 1'b1;
            end
            OpOri: begin
                dec_o.cls = ClsAluImm; dec_o.alu_src = 1'b1; dec_o.alu_op = AluOr;
                dec_o.is_unsigned = 1'b1;
            end
            OpXori: begin
                dec_o.cls = ClsAluImm; dec_o.alu_src = 1'b1; dec_o.alu_op = AluXor;
                dec_o.is_unsigned = 1'b1;
            end
            OpLui: begin
                dec_o.cls = ClsAluImm; dec_o.alu_src = 1'b1; dec_o.alu_op = AluLui;
            end
            OpLw: begin
                dec_o.cls = ClsLoad; dec_o.alu_src = 1'b1; dec_o.alu_op = AluAdd;
            end
            OpSw: begin
                dec_o.cls = ClsStore; dec_o.alu_src = 1'b1; dec_o.alu_op = AluAdd;
            end
            OpBeq:    begin dec_o.cls = ClsBranch; dec_o.br = BrEq;  dec_o.alu_op = AluSub; end
            OpBne:    begin dec_o.cls = ClsBranch; dec_o.br = BrNe;  dec_o.alu_op = AluSub; end
            OpBlez:   begin dec_o.cls = ClsBranch; dec_o.br = BrLez; dec_o.alu_op = AluSub; end
            OpBgtz:   begin dec_o.cls = ClsBranch; dec_o.br = BrGtz; dec_o.alu_op = AluSub; end
            OpRegimm: begin dec_o.cls = ClsBranch; dec_o.br = BrGez; dec_o.alu_op = AluSub; end
            OpJ:      dec_o.cls = ClsJump;
            OpJal:    dec_o.cls = ClsJal;
            default:  dec_o.cls = ClsIllegal;
        endcase
        dec_o.illegal = (dec_o.cls == ClsIllegal);
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MULDIV_WAIT/MEM/WB/HALT with a
// ready/valid memory handshake and a fixed-latency MULT/DIV stall.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES  = 8,
    parameter int unsigned ALU_OP_W       = 4,
    parameter int unsigned PC_LINK_OFFSET = 8
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic [5:0]          opcode,
    input  logic [5:0]          func,
    input  logic                zero,
    input  logic                negative,
    input  logic                mem_ready,
    output logic                mem_read_en,
    output logic                mem_write_en,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                alu_src,
    output logic [1:0]          reg_dest,
    output logic [1:0]          wb_src,
    output logic                reg_write_enable,
    output logic                does_shift_amount_need,
    output logic                is_unsigned,
    output logic [ALU_OP_W-1:0] alu_operation,
    output logic                muldiv_start,
    output logic [3:0]          link_offset,
    output logic                halted,
    output logic                illegal_instr,
    output logic [2:0]          state_o
);

    localparam logic [5:0] MdLoad = 6'(MULDIV_CYCLES - 1);

    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       illegal_q, illegal_d;
    dec_t       dec;
    logic       br_taken;

    logic       mem_read_c, mem_write_c, i_or_d_c, ir_write_c, pc_write_c;
    logic       alu_src_c, reg_write_c, shamt_c, unsigned_c, muldiv_start_c;
    pc_src_e    pc_src_c;
    reg_dest_e  reg_dest_c;
    wb_src_e    wb_src_c;
    logic [3:0] alu_op_c;

    mcu_decode u_decode (
        .opcode_i (opcode),
        .func_i   (func),
        .dec_o    (dec)
    );

    always_comb begin
        case (dec.br)
            BrEq:    br_taken = zero;
            BrNe:    br_taken = !zero;
            BrLez:   br_taken = zero || negative;
            BrGtz:   br_taken = !zero && !negative;
            BrGez:   br_taken = !negative;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        illegal_d      = illegal_q;
        mem_read_c     = 1'b0;
        mem_write_c    = 1'b0;
        i_or_d_c       = 1'b0;
        ir_write_c     = 1'b0;
        pc_write_c     = 1'b0;
        pc_src_c       = PcSrcPlus4;
        alu_src_c      = 1'b0;
        reg_dest_c     = DestRt;
        wb_src_c       = WbAlu;
        reg_write_c    = 1'b0;
        shamt_c        = 1'b0;
        unsigned_c     = 1'b0;
        alu_op_c       = AluAdd;
        muldiv_start_c = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem_read_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = StDecode;
                end
            end
            StDecode: begin
                if (dec.cls == ClsSyscall) begin
                    state_d = StHalt;
                end else if (dec.illegal) begin
                    illegal_d = 1'b1;
                    state_d   = StFetch;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                alu_op_c   = dec.alu_op;
                alu_src_c  = dec.alu_src;
                shamt_c    = dec.shamt;
                unsigned_c = dec.is_unsigned;
                state_d    = StFetch;
                case (dec.cls)
                    ClsAluR, ClsAluImm: state_d = StWb;
                    ClsLoad, ClsStore:  state_d = StMem;
                    ClsMulDiv: begin
                        muldiv_start_c = 1'b1;
                        cnt_d          = MdLoad;
                        state_d        = (MULDIV_CYCLES <= 1) ? StWb : StMuldivWait;
                    end
                    ClsBranch: begin
                        pc_write_c = br_taken;
                        pc_src_c   = PcSrcBranch;
                    end
                    ClsJump: begin
                        pc_write_c = 1'b1;
                        pc_src_c   = PcSrcJump;
                    end
                    ClsJr: begin
                        pc_write_c = 1'b1;
                        pc_src_c   = PcSrcReg;
                    end
                    ClsJal: begin
                        pc_write_c = 1'b1;
                        pc_src_c   = PcSrcJump;
                        state_d    = StWb;
                    end
                    default: state_d = StFetch;
                endcase
            end
            // cnt_q holds the wait cycles still owed; the last one hands over to WB.
            StMuldivWait: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q <= 6'd1) begin
                    state_d = StWb;
                end
            end
            StMem: begin
                i_or_d_c    = 1'b1;
                mem_read_c  = (dec.cls == ClsLoad);
                mem_write_c = (dec.cls != ClsLoad);
                if (mem_ready) begin
                    state_d = (dec.cls == ClsLoad) ? StWb : StFetch;
                end
            end
            StWb: begin
                reg_write_c = 1'b1;
                state_d     = StFetch;
                case (dec.cls)
                    ClsAluR:   begin reg_dest_c = DestRd;  wb_src_c = WbAlu;    end
                    ClsLoad:   begin reg_dest_c = DestRt;  wb_src_c = WbMem;    end
                    ClsJal:    begin reg_dest_c = DestR31; wb_src_c = WbLink;   end
                    ClsMulDiv: begin reg_dest_c = DestRd;  wb_src_c = WbMulDiv; end
                    default:   begin reg_dest_c = DestRt;  wb_src_c = WbAlu;    end
                endcase
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= StFetch;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    // Outputs are forced low while reset is held so requests drop without a clock edge.
    assign mem_read_en            = rst_b & mem_read_c;
    assign mem_write_en           = rst_b & mem_write_c;
    assign i_or_d                 = rst_b & i_or_d_c;
    assign ir_write               = rst_b & ir_write_c;
    assign pc_write               = rst_b & pc_write_c;
    assign pc_src                 = rst_b ? pc_src_c : 2'd0;
    assign alu_src                = rst_b & alu_src_c;
    assign reg_dest               = rst_b ? reg_dest_c : 2'd0;
    assign wb_src                 = rst_b ? wb_src_c : 2'd0;
    assign reg_write_enable       = rst_b & reg_write_c;
    assign does_shift_amount_need = rst_b & shamt_c;
    assign is_unsigned            = rst_b & unsigned_c;
    assign alu_operation          = rst_b ? ALU_OP_W'(alu_op_c) : '0;
    assign muldiv_start           = rst_b & muldiv_start_c;
    assign link_offset            = rst_b ? 4'(PC_LINK_OFFSET) : 4'd0;
    assign halted                 = rst_b & (state_q == StHalt);
    assign illegal_instr          = rst_b & illegal_q;
    assign state_o                = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks instruction classes through the FSM
// and compares control outputs against hand-derived values.
module tb_multicycle_control_unit;

    logic       clk, rst_b;
    logic [5:0] opcode, func;
    logic       zero, negative, mem_ready;
    logic       mem_read_en, mem_write_en, i_or_d, ir_write, pc_write;
    logic [1:0] pc_src, reg_dest, wb_src;
    logic       alu_src, reg_write_enable, does_shift_amount_need, is_unsigned;
    logic [3:0] alu_operation, link_offset;
    logic       muldiv_start, halted, illegal_instr;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_errors = 0;
    int cycles   = 0;

    multicycle_control_unit #(
        .MULDIV_CYCLES  (8),
        .ALU_OP_W       (4),
        .PC_LINK_OFFSET (8)
    ) dut (
        .clk                    (clk),
        .rst_b                  (rst_b),
        .opcode                 (opcode),
        .func                   (func),
        .zero                   (zero),
        .negative               (negative),
        .mem_ready              (mem_ready),
        .mem_read_en            (mem_read_en),
        .mem_write_en           (mem_write_en),
        .i_or_d                 (i_or_d),
        .ir_write               (ir_write),
        .pc_write               (pc_write),
        .pc_src                 (pc_src),
        .alu_src                (alu_src),
        .reg_dest               (reg_dest),
        .wb_src                 (wb_src),
        .reg_write_enable       (reg_write_enable),
        .does_shift_amount_need (does_shift_amount_need),
        .is_unsigned            (is_unsigned),
        .alu_operation          (alu_operation),
        .muldiv_start           (muldiv_start),
        .link_offset            (link_offset),
        .halted                 (halted),
        .illegal_instr          (illegal_instr),
        .state_o                (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycles++;
    endtask

    // Zero-wait fetch of one instruction, then the single DECODE cycle.
    task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
        opcode    = op;
        func      = fn;
        mem_ready = 1'b1;
        #1;
        check("fetch_state", 32'(state_o), 0);
        check("fetch_rd", 32'(mem_read_en), 1);
        check("fetch_irw", 32'(ir_write), 1);
        check("fetch_pcw", 32'(pc_write), 1);
        tick();
        mem_ready = 1'b0;
        #1;
        check("decode_state", 32'(state_o), 1);
        tick();
    endtask

    initial begin
        int wb_at;
        int start;
        rst_b = 1'b0; opcode = '0; func = '0; zero = 1'b0; negative = 1'b0; mem_ready = 1'b1;
        #2;
        check("rst_state", 32'(state_o), 0);
        check("rst_rd", 32'(mem_read_en), 0);
        check("rst_irw", 32'(ir_write), 0);
        check("rst_link", 32'(link_offset), 0);
        check("rst_halt", 32'(halted), 0);
        #10;
        rst_b = 1'b1;
        #1;
        check("post_rst_link", 32'(link_offset), 8);
        check("post_rst_rd", 32'(mem_read_en), 1);

        // ADD
        fetch_decode(6'b000000, 6'b100000);
        #1;
        check("add_exec_state", 32'(state_o), 2);
        check("add_aluop", 32'(alu_operation), 0);
        check("add_alusrc", 32'(alu_src), 0);
        check("add_exec_rwe", 32'(reg_write_enable), 0);
        tick();
        check("add_wb_state", 32'(state_o), 5);
        check("add_wb_rwe", 32'(reg_write_enable), 1);
        check("add_wb_dest", 32'(reg_dest), 1);
        check("add_wb_src", 32'(wb_src), 0);
        tick();
        check("add_done_state", 32'(state_o), 0);
        check("add_done_rwe", 32'(reg_write_enable), 0);

        // LW with three wait cycles in both FETCH and MEM
        start  = cycles;
        opcode = 6'b100011;
        func   = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            check("lw_f_rd", 32'(mem_read_en), 1);
            check("lw_f_iord", 32'(i_or_d), 0);
            check("lw_f_irw", 32'(ir_write), (i == 3) ? 1 : 0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("lw_dec_state", 32'(state_o), 1);
        check("lw_dec_rd", 32'(mem_read_en), 0);
        tick();
        check("lw_exec_state", 32'(state_o), 2);
        check("lw_exec_alusrc", 32'(alu_src), 1);
        check("lw_exec_iord", 32'(i_or_d), 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            check("lw_m_state", 32'(state_o), 4);
            check("lw_m_rd", 32'(mem_read_en), 1);
            check("lw_m_wr", 32'(mem_write_en), 0);
            check("lw_m_iord", 32'(i_or_d), 1);
            tick();
        end
        mem_ready = 1'b0;
        check("lw_wb_state", 32'(state_o), 5);
        check("lw_wb_src", 32'(wb_src), 1);
        check("lw_wb_dest", 32'(reg_dest), 0);
        tick();
        check("lw_cycles", 32'(cycles - start), 11);
        check("lw_done_state", 32'(state_o), 0);

        // ORI: zero-extended immediate, writes rt
        fetch_decode(6'b001101, 6'b000000);
        #1;
        check("ori_aluop", 32'(alu_operation), 3);
        check("ori_alusrc", 32'(alu_src), 1);
        check("ori_unsigned", 32'(is_unsigned), 1);
        tick();
        check("ori_wb_dest", 32'(reg_dest), 0);
        check("ori_wb_src", 32'(wb_src), 0);
        tick();

        // SRL uses shamt
        fetch_decode(6'b000000, 6'b000010);
        #1;
        check("srl_aluop", 32'(alu_operation), 9);
        check("srl_shamt", 32'(does_shift_amount_need), 1);
        tick();
        tick();

        // BEQ taken / not taken, BLEZ on negative
        fetch_decode(6'b000100, 6'b000000);
        zero = 1'b1;
        #1;
        check("beq_t_pcw", 32'(pc_write), 1);
        check("beq_t_pcsrc", 32'(pc_src), 1);
        check("beq_t_aluop", 32'(alu_operation), 1);
        tick();
        check("beq_t_next", 32'(state_o), 0);
        fetch_decode(6'b000100, 6'b000000);
        zero = 1'b0;
        #1;
        check("beq_nt_pcw", 32'(pc_write), 0);
        tick();
        check("beq_nt_next", 32'(state_o), 0);
        fetch_decode(6'b000110, 6'b000000);
        negative = 1'b1;
        #1;
        check("blez_pcw", 32'(pc_write), 1);
        tick();
        negative = 1'b0;

        // JAL
        fetch_decode(6'b000011, 6'b000000);
        #1;
        check("jal_pcw", 32'(pc_write), 1);
        check("jal_pcsrc", 32'(pc_src), 2);
        tick();
        check("jal_wb_state", 32'(state_o), 5);
        check("jal_wb_dest", 32'(reg_dest), 2);
        check("jal_wb_src", 32'(wb_src), 2);
        check("jal_wb_rwe", 32'(reg_write_enable), 1);
        tick();

        // JR
        fetch_decode(6'b000000, 6'b001000);
        #1;
        check("jr_pcsrc", 32'(pc_src), 3);
        check("jr_pcw", 32'(pc_write), 1);
        tick();
        check("jr_next", 32'(state_o), 0);

        // MULT: WB lands exactly MULDIV_CYCLES after EXEC
        fetch_decode(6'b000000, 6'b011000);
        #1;
        check("mult_start", 32'(muldiv_start), 1);
        tick();
        check("mult_start_drop", 32'(muldiv_start), 0);
        check("mult_wait_state", 32'(state_o), 3);
        wb_at = 0;
        for (int k = 1; k <= 20; k++) begin
            if (state_o == 3'd5) begin
                wb_at = k;
                break;
            end
            tick();
        end
        check("mult_wb_dist", 32'(wb_at), 8);
        check("mult_wb_src", 32'(wb_src), 3);
        check("mult_wb_dest", 32'(reg_dest), 1);
        tick();

        // Illegal opcode, then a normal ADD
        fetch_decode(6'b111111, 6'b000000);
        #1;
        check("ill_next", 32'(state_o), 0);
        check("ill_flag", 32'(illegal_instr), 1);
        fetch_decode(6'b000000, 6'b100000);
        #1;
        check("ill_after_exec", 32'(state_o), 2);
        tick();
        check("ill_after_wb", 32'(reg_write_enable), 1);
        tick();

        // SW with reset dropped mid-MEM
        fetch_decode(6'b101011, 6'b000000);
        tick();
        check("sw_mem_state", 32'(state_o), 4);
        check("sw_mem_wr", 32'(mem_write_en), 1);
        check("sw_mem_rd", 32'(mem_read_en), 0);
        #1;
        rst_b = 1'b0;
        #1;
        check("sw_rst_wr", 32'(mem_write_en), 0);
        check("sw_rst_state", 32'(state_o), 0);
        check("sw_rst_ill", 32'(illegal_instr), 0);
        #20;
        rst_b = 1'b1;
        #1;
        check("sw_rel_state", 32'(state_o), 0);
        check("sw_rel_rd", 32'(mem_read_en), 1);
        check("sw_rel_ill", 32'(illegal_instr), 0);

        // SYSCALL halts for good
        fetch_decode(6'b000000, 6'b001100);
        #1;
        check("sys_state", 32'(state_o), 6);
        check("sys_halted", 32'(halted), 1);
        mem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("halt_rd", 32'(mem_read_en), 0);
            check("halt_flag", 32'(halted), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle successor to the single-cycle MIPS control unit. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states with a ready/valid memory handshake and a parametrised multi-cycle MULT/DIV stall. It adds LW/SW, JAL writeback of PC+8 and an illegal-instruction flag. It sits between the instruction register and the shared datapath (ALU, register file, memory port, PC).

Parameters:
MULDIV_CYCLES, 8, cycles the MULT/DIV unit needs after start (legal range 1..63)
ALU_OP_W, 4, width of alu_operation
PC_LINK_OFFSET, 8, value the PC adder uses for the JAL link (driven out as a constant; 4 or 8 legal)

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]; datapath holds it stable after ir_write
func  in  6  IR[5:0]
zero  in  1  ALU result == 0
negative  in  1  ALU result sign
mem_ready  in  1  memory completes the current read/write this cycle
mem_read_en  out  1  memory read request (fetch or LW)
mem_write_en  out  1  memory write request (SW)
i_or_d  out  1  memory address source: 0 = PC, 1 = ALU result
ir_write  out  1  load IR from memory data
pc_write  out  1  update PC
pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs (JR)
alu_src  out  1  ALU B operand: 0 = rt, 1 = immediate
reg_dest  out  2  0 = rt, 1 = rd, 2 = r31
wb_src  out  2  0 = ALU, 1 = memory data, 2 = PC link, 3 = MULT/DIV result
reg_write_enable  out  1  register file write, single-cycle pulse
does_shift_amount_need  out  1  ALU A operand is shamt
is_unsigned  out  1  zero-extend immediate
alu_operation  out  ALU_OP_W  ALU function
muldiv_start  out  1  one-cycle start pulse to the MULT/DIV unit
link_offset  out  4  constant PC_LINK_OFFSET
halted  out  1  sticky after SYSCALL
illegal_instr  out  1  sticky after an unknown opcode/func
state_o  out  3  current state, for debug

Behaviour:
- Reset (rst_b = 0, asynchronous): state = FETCH; all outputs 0; halted, illegal_instr and the MULT/DIV counter cleared. This also applies mid-instruction and takes effect immediately, not at the next edge.
- States: FETCH, DECODE, EXEC, MULDIV_WAIT, MEM, WB, HALT. Outputs are Moore outputs of the state plus the decode of opcode/func.
- FETCH: mem_read_en = 1, i_or_d = 0; held until mem_ready is seen.
  - In the mem_ready cycle: ir_write = 1, pc_write = 1, pc_src = 0, then go to DECODE.
  - A zero-wait fetch (mem_ready high in the first cycle) is one cycle long.
- DECODE: always one cycle.
  - SYSCALL -> HALT.
  - Unknown opcode/func -> set illegal_instr, then FETCH (executed as a NOP).
  - Everything else -> EXEC.
- EXEC: ALU controls asserted as for the single-cycle unit.
  - R-type/immediate ALU ops -> WB.
  - LW/SW -> MEM.
  - MULT/DIV: muldiv_start = 1, counter loaded with MULDIV_CYCLES-1 -> MULDIV_WAIT.
  - BEQ/BNE/BLEZ/BGTZ/BGEZ: zero/negative sampled in this cycle. If taken, pc_write = 1 and pc_src = 1. -> FETCH.
  - J: pc_write, pc_src = 2 -> FETCH. JR: pc_write, pc_src = 3 -> FETCH.
  - JAL: pc_write, pc_src = 2 -> WB.
- MULDIV_WAIT: counter decrements each cycle; move to WB on the cycle it reads 0. Total EXEC-to-WB distance is exactly MULDIV_CYCLES cycles. MULDIV_CYCLES = 1 skips MULDIV_WAIT (EXEC -> WB).
- MEM: i_or_d = 1; mem_read_en (LW) or mem_write_en (SW) held until mem_ready.
  - On mem_ready: LW -> WB, SW -> FETCH.
- WB: reg_write_enable = 1 for exactly one cycle, then FETCH.
  - reg_dest/wb_src per instruction: ALU R-type 1/0; immediate 0/0; LW 0/1; JAL 2/2; MULT/DIV 1/3.
- HALT: absorbing; all request/write outputs 0; halted = 1 until reset.
- mem_ready outside FETCH/MEM is ignored.
- mem_read_en and mem_write_en are never both 1.
- Write enables never assert outside their state.
- CPI with zero-wait memory: R-type 4, LW 5, SW 4, branch/J/JR 3, JAL 4, MULT/DIV 3 + MULDIV_CYCLES.

Decomposition:
- Shared package mcu_pkg:
  - opcode/func localparams, including LW = 100011, SW = 101011 and MULT/DIV.
  - State enum.
  - pc_src, wb_src and reg_dest encodings.
- One sub-module, mcu_decode: pure combinational opcode/func -> instruction class, ALU controls, is_unsigned and illegal. The top holds the FSM and counter.

Test Plan:
- ADD, zero-wait memory -> states FETCH, DECODE, EXEC, WB; reg_write_enable pulses once in cycle 4 with reg_dest = 1, wb_src = 0.
- LW, mem_ready delayed 3 cycles in both FETCH and MEM -> mem_read_en held 4 cycles each phase; i_or_d = 1 only in MEM; WB has wb_src = 1; 11 cycles total.
- BEQ with zero = 1 -> pc_write with pc_src = 1 in EXEC. Same with zero = 0 -> no pc_write in EXEC; next state FETCH.
- MULT with MULDIV_CYCLES = 8 -> muldiv_start in one cycle; WB exactly 8 cycles later; wb_src = 3.
- SYSCALL -> halted = 1 from the cycle after DECODE onward; no further mem_read_en across 20 cycles. Separately, opcode 111111 -> illegal_instr = 1, next instruction fetched normally.
- rst_b dropped mid-MEM of an SW -> mem_write_en falls to 0 without a clock edge; after release, the FSM restarts in FETCH with flags clear.
